// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: issues LANES single-word memory accesses from
// ea = base + sext(offset), stepping by stride, with ready-based handshake.
module vec_mem_seq #(
  parameter int WORD_W = 16,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16,
  parameter int OFF_W  = 6
) (
  input  logic                    clk1,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [OFF_W-1:0]        offset,
  input  logic [ADDR_W-1:0]       stride,
  input  logic [LANES*WORD_W-1:0] wdata_vec,
  input  logic [WORD_W-1:0]       mem_rdata,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic [WORD_W-1:0]       mem_wdata,
  output logic [LANES*WORD_W-1:0] rdata_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    wrap
);
  localparam int KW = $clog2(LANES);
  localparam int AW = ADDR_W + LANES;
  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_XFER = 2'd2, S_DONE = 2'd3;
  localparam logic [KW-1:0] K_LAST = KW'(LANES-1);

  logic [1:0]                   r_state;
  logic [KW-1:0]                r_k;
  logic                         r_op;
  logic                         r_iss;
  logic [ADDR_W-1:0]            r_base;
  logic [ADDR_W-1:0]            r_stride;
  logic [OFF_W-1:0]             r_off;
  logic [LANES-1:0][WORD_W-1:0] r_wvec;
  logic [LANES-1:0][WORD_W-1:0] r_rvec;
  logic [AW-1:0]                r_acc;
  logic [ADDR_W-1:0]            w_ea;
  logic [AW-1:0]                w_nacc;
  logic [KW-1:0]                w_kn;

  assign w_ea      = r_base + {{(ADDR_W-OFF_W){r_off[OFF_W-1]}}, r_off};
  // Running lane address kept wide so the carry out of ADDR_W flags a wrap.
  assign w_nacc    = r_acc + AW'(r_stride);
  assign w_kn      = r_k + 1'b1;
  assign rdata_vec = r_rvec;

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_op      <= 1'b0;
      r_iss     <= 1'b0;
      r_base    <= '0;
      r_stride  <= '0;
      r_off     <= '0;
      r_wvec    <= '0;
      r_rvec    <= '0;
      r_acc     <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op     <= op;
          r_base   <= base_addr;
          r_off    <= offset;
          r_stride <= stride;
          r_wvec   <= wdata_vec;
          busy     <= 1'b1;
          r_state  <= S_ADDR;
        end
        S_ADDR: begin
          r_acc   <= AW'(w_ea);
          r_k     <= '0;
          wrap    <= 1'b0;
          r_iss   <= 1'b0;
          r_state <= S_XFER;
        end
        S_XFER: begin
          // First XFER cycle loads the lane-0 request; ready is not looked at yet.
          if (!r_iss) begin
            r_iss     <= 1'b1;
            mem_addr  <= r_acc[ADDR_W-1:0];
            mem_rd    <= ~r_op;
            mem_wr    <= r_op;
            mem_wdata <= r_wvec[r_k];
          end else if (mem_ready) begin
            if (!r_op) r_rvec[r_k] <= mem_rdata;
            if (r_k == K_LAST) begin
              mem_rd  <= 1'b0;
              mem_wr  <= 1'b0;
              done    <= 1'b1;
              r_iss   <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_k       <= w_kn;
              r_acc     <= w_nacc;
              mem_addr  <= w_nacc[ADDR_W-1:0];
              mem_wdata <= r_wvec[w_kn];
              wrap      <= wrap | (|w_nacc[AW-1:ADDR_W]);
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: 16-lane/16-bit instance plus a 4-lane/32-bit instance.
module tb_vec_mem_seq;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  // 16-lane instance
  logic         start1 = 0, op1 = 0, rdy_base = 1, stall_on = 0;
  logic [15:0]  base1 = 0, stride1 = 0, addr1, wdata1, rdata1;
  logic [5:0]   off1 = 0;
  logic [255:0] wvec1 = 0, rvec1;
  logic         rdy1, rd1, wr1, busy1, done1, wrap1;
  // 4-lane instance
  logic         start2 = 0, op2 = 0, rdy2 = 1;
  logic [15:0]  base2 = 0, stride2 = 0, addr2;
  logic [5:0]   off2 = 0;
  logic [31:0]  wdata2, rdata2;
  logic [127:0] wvec2 = 0, rvec2;
  logic         rd2, wr2, busy2, done2, wrap2;

  vec_mem_seq dut1 (
    .clk1(clk1), .rst(rst), .start(start1), .op(op1), .base_addr(base1), .offset(off1),
    .stride(stride1), .wdata_vec(wvec1), .mem_rdata(rdata1), .mem_ready(rdy1),
    .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1), .mem_wdata(wdata1), .rdata_vec(rvec1),
    .busy(busy1), .done(done1), .wrap(wrap1));

  vec_mem_seq #(.WORD_W(32), .LANES(4)) dut2 (
    .clk1(clk1), .rst(rst), .start(start2), .op(op2), .base_addr(base2), .offset(off2),
    .stride(stride2), .wdata_vec(wvec2), .mem_rdata(rdata2), .mem_ready(rdy2),
    .mem_addr(addr2), .mem_rd(rd2), .mem_wr(wr2), .mem_wdata(wdata2), .rdata_vec(rvec2),
    .busy(busy2), .done(done2), .wrap(wrap2));

  // Memory model: unwritten words read as addr ^ 16'h5A5A
  logic [15:0] mem [0:65535];
  bit          mvalid [0:65535];
  int          stall_n = 0, l4_cyc = 0, l4_bad = 0, wcnt = 0, w2cnt = 0;
  bit          rdwr_bad = 0, idle_bad = 0;
  logic [15:0] rlog [$];
  logic [15:0] w2addr;
  logic [31:0] w2data;
  logic        rr;

  function automatic logic [15:0] mv(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always_comb rdata1 = mvalid[addr1] ? mem[addr1] : (addr1 ^ 16'h5A5A);
  assign rdy1   = rdy_base & ~(stall_on && wr1 && addr1 == 16'h002D && stall_n < 3);
  assign rdata2 = {addr2, ~addr2};

  always @(posedge clk1) begin
    rr = rdy1;
    if (rd1 && wr1) rdwr_bad = 1;
    if ((!busy1 || done1) && (rd1 || wr1)) idle_bad = 1;
    if (stall_on && wr1 && addr1 == 16'h002D) begin
      l4_cyc++;
      if (wdata1 !== 16'hA004 || rd1) l4_bad++;
      if (!rr) stall_n <= stall_n + 1;
    end
    if (rd1 && rr) rlog.push_back(addr1);
    if (wr1 && rr) begin
      mem[addr1]    <= wdata1;
      mvalid[addr1] <= 1'b1;
      wcnt++;
    end
    if (wr2 && rdy2) begin
      w2cnt++;
      w2addr = addr2;
      w2data = wdata2;
    end
  end

  int ncmp = 0, nfail = 0;
  int lat, nd, w0, found;
  logic [255:0] e1, e3;
  logic [15:0]  a;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go1(input logic o, input logic [15:0] b, input logic [5:0] of,
                     input logic [15:0] s, input logic [255:0] w);
    @(negedge clk1);
    start1 = 1; op1 = o; base1 = b; off1 = of; stride1 = s; wvec1 = w;
    @(negedge clk1);
    start1 = 0;
  endtask

  task automatic go2(input logic o, input logic [15:0] b, input logic [5:0] of,
                     input logic [15:0] s, input logic [127:0] w);
    @(negedge clk1);
    start2 = 1; op2 = o; base2 = b; off2 = of; stride2 = s; wvec2 = w;
    @(negedge clk1);
    start2 = 0;
  endtask

  // Edges after the start-sampling edge until done; also counts done pulses.
  task automatic wait_done(input bit d2, input int poke, output int l, output int n);
    l = -1; n = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk1); #1;
      if (c == poke) begin start1 = 1; op1 = 1; base1 = 16'h0300; stride1 = 16'd7; end
      if (c == poke + 1) start1 = 0;
      if (d2 ? done2 : done1) begin
        if (l < 0) l = c;
        n++;
      end
      if (l >= 0 && c >= l + 8) break;
    end
  endtask

  initial begin
    #2 rst = 0;
    repeat (2) @(negedge clk1);
    #1;
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_wrap", wrap1, 0);
    chk("rst_rdwr", {rd1, wr1}, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_wdata", wdata1, 0);
    chk("rst_rvec", rvec1, 0);
    chk("rst_rvec2", rvec2, 0);

    // Load, offset -2, stride 1; start on the first edge after reset release
    @(negedge clk1);
    rst = 1; start1 = 1; op1 = 0; base1 = 16'h0100; off1 = 6'h3E; stride1 = 16'd1; wvec1 = '0;
    @(posedge clk1); #1;
    chk("first_start_busy", busy1, 1);
    @(negedge clk1); start1 = 0;
    wait_done(0, -10, lat, nd);
    for (int k = 0; k < 16; k++) e1[k*16 +: 16] = mv(16'h00FE + 16'(k));
    chk("ld1_latency", lat, 18);
    chk("ld1_ndone", nd, 1);
    chk("ld1_nreads", rlog.size(), 16);
    chk("ld1_addr0", rlog[0], 16'h00FE);
    chk("ld1_addr15", rlog[15], 16'h010D);
    chk("ld1_rvec", rvec1, e1);
    chk("ld1_wrap", wrap1, 0);
    chk("ld1_idle", {busy1, rd1}, 0);

    // Store with 3 wait cycles on lane 4
    rlog.delete();
    stall_on = 1;
    for (int k = 0; k < 16; k++) e3[k*16 +: 16] = 16'hA000 + 16'(k);
    go1(1, 16'h0020, 6'd5, 16'd2, e3);
    wait_done(0, -10, lat, nd);
    stall_on = 0;
    chk("st_latency", lat, 21);
    chk("st_lane4_cycles", l4_cyc, 4);
    chk("st_lane4_stable", l4_bad, 0);
    chk("st_nwrites", wcnt, 16);
    chk("st_mem_l0", mem[16'h0025], 16'hA000);
    chk("st_mem_l4", mem[16'h002D], 16'hA004);
    chk("st_mem_l15", mem[16'h0043], 16'hA00F);
    chk("st_no_reads", rlog.size(), 0);
    chk("st_rvec_kept", rvec1, e1);

    // Load crossing 0xFFFF
    go1(0, 16'hFFF8, 6'd0, 16'd1, '0);
    wait_done(0, -10, lat, nd);
    for (int k = 0; k < 16; k++) begin
      a = 16'hFFF8 + 16'(k);
      e3[k*16 +: 16] = mv(a);
    end
    chk("wrap_latency", lat, 18);
    chk("wrap_addr8", rlog[8], 16'h0000);
    chk("wrap_addr15", rlog[15], 16'h0007);
    chk("wrap_rvec", rvec1, e3);
    chk("wrap_flag", wrap1, 1);

    // Load with a second start pulse at cycle 5
    rlog.delete();
    w0 = wcnt;
    go1(0, 16'h0200, 6'd0, 16'd3, '0);
    wait_done(0, 5, lat, nd);
    for (int k = 0; k < 16; k++) e1[k*16 +: 16] = mv(16'h0200 + 16'(3*k));
    chk("ign_latency", lat, 18);
    chk("ign_ndone", nd, 1);
    chk("ign_nreads", rlog.size(), 16);
    chk("ign_addr15", rlog[15], 16'h022D);
    chk("ign_no_writes", wcnt - w0, 0);
    chk("ign_rvec", rvec1, e1);
    chk("ign_wrap_clr", wrap1, 0);
    chk("ign_idle", busy1, 0);

    // Reset mid-store at lane 7
    w0 = wcnt; found = 0;
    for (int k = 0; k < 16; k++) e3[k*16 +: 16] = 16'hB000 + 16'(k);
    go1(1, 16'h0400, 6'd0, 16'd1, e3);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk1); #1;
      if (wr1 && addr1 == 16'h0407) begin found = 1; break; end
    end
    chk("rst_lane7_reached", found, 1);
    rst = 0;
    #1;
    chk("abort_wr", wr1, 0);
    chk("abort_outs", {rd1, busy1, done1, wrap1, addr1, wdata1}, 0);
    chk("abort_rvec", rvec1, 0);
    chk("abort_nwrites", wcnt - w0, 7);
    chk("abort_mem6", mem[16'h0406], 16'hB006);
    repeat (3) @(negedge clk1);
    chk("abort_no_more_writes", wcnt - w0, 7);
    chk("abort_mem7_untouched", rdata1 === 16'h0000 ? 1'b0 : mvalid[16'h0407], 0);
    rst = 1;
    rlog.delete();
    go1(0, 16'h0100, 6'h3E, 16'd1, '0);
    wait_done(0, -10, lat, nd);
    for (int k = 0; k < 16; k++) e1[k*16 +: 16] = mv(16'h00FE + 16'(k));
    chk("post_rst_latency", lat, 18);
    chk("post_rst_rvec", rvec1, e1);

    // 4-lane, 32-bit instance
    go2(0, 16'h0010, 6'h3F, 16'd4, '0);
    wait_done(1, -10, lat, nd);
    chk("l4_latency", lat, 6);
    chk("l4_ndone", nd, 1);
    chk("l4_rvec", rvec2, 128'h001B_FFE4_0017_FFE8_0013_FFEC_000F_FFF0);
    chk("l4_wrap", wrap2, 0);
    go2(1, 16'h0050, 6'd0, 16'd0, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000);
    wait_done(1, -10, lat, nd);
    chk("s0_latency", lat, 6);
    chk("s0_nwrites", w2cnt, 4);
    chk("s0_addr", w2addr, 16'h0050);
    chk("s0_last_data", w2data, 32'hCAFE0003);
    chk("s0_rvec_kept", rvec2, 128'h001B_FFE4_0017_FFE8_0013_FFEC_000F_FFF0);

    chk("never_rd_and_wr", rdwr_bad, 0);
    chk("no_req_outside_xfer", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/vec_mem_seq.md
VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 Parameter WORD_W, default 16, memory word width in bits.
REQ-002 Parameter LANES, default 16, words per vector transfer (LANES >= 2).
REQ-003 Parameter ADDR_W, default 16, memory address width.
REQ-004 Parameter OFF_W, default 6, width of the signed instruction offset field.
REQ-005 clk1  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request pulse; sampled only in IDLE.
REQ-008 op  in  1  0 = vector load, 1 = vector store.
REQ-009 base_addr  in  ADDR_W  base address.
REQ-010 offset  in  OFF_W  two's-complement offset.
REQ-011 stride  in  ADDR_W  unsigned address increment between lanes.
REQ-012 wdata_vec  in  LANES*WORD_W  store data; lane k occupies bits [k*WORD_W +: WORD_W].
REQ-013 mem_rdata  in  WORD_W  memory read data, valid when mem_ready = 1.
REQ-014 mem_ready  in  1  memory accepts or completes the current access this cycle.
REQ-015 mem_addr  out  ADDR_W  memory address.
REQ-016 mem_rd  out  1  read request.
REQ-017 mem_wr  out  1  write request.
REQ-018 mem_wdata  out  WORD_W  write data.
REQ-019 rdata_vec  out  LANES*WORD_W  assembled load data, same lane packing as wdata_vec.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle completion pulse.
REQ-022 wrap  out  1  high when any lane address of the last transfer wrapped past 2^ADDR_W-1.

Function
REQ-023 The FSM SHALL have the states IDLE, ADDR, XFER and DONE; all outputs are registered.
REQ-024 IDLE SHALL move to ADDR when start = 1, and SHALL in the same edge latch op, base_addr, offset, stride and wdata_vec.
REQ-025 ADDR SHALL compute ea = base_addr + sign-extended offset, modulo 2^ADDR_W, SHALL clear the lane counter k and wrap, and SHALL then move to XFER.
REQ-026 XFER SHALL drive mem_addr = ea + k*stride (mod 2^ADDR_W), drive mem_rd = ~op and mem_wr = op, and drive mem_wdata = lane k of the latched wdata_vec.
REQ-027 In XFER, mem_rd, mem_wr, mem_addr and mem_wdata SHALL hold stable until mem_ready = 1, with unlimited wait cycles allowed.
REQ-028 On a cycle with mem_ready = 1 during a load, lane k of rdata_vec SHALL capture mem_rdata; no other lane SHALL change.
REQ-029 On a cycle with mem_ready = 1 and k < LANES-1, k SHALL increment and the FSM SHALL stay in XFER; with k = LANES-1 it SHALL move to DONE.
REQ-030 wrap SHALL set if ea + k*stride, computed at ADDR_W+LANES bits, exceeds 2^ADDR_W-1 for any issued lane; wrap SHALL be sticky until the next ADDR state.
REQ-031 DONE SHALL assert done for exactly one cycle, deassert mem_rd and mem_wr, and return to IDLE.
REQ-032 mem_rd and mem_wr SHALL never both be 1 and SHALL both be 0 outside XFER.
REQ-033 start while busy = 1 SHALL be ignored, with no queuing and no change to latched operands.
REQ-034 rdata_vec SHALL hold its value from load completion until a later load overwrites it lane by lane; a store SHALL leave rdata_vec unchanged.
REQ-035 With mem_ready held at 1, done SHALL rise LANES+2 edges after the edge that sampled start.
REQ-036 A stride of 0 SHALL access ea LANES times, and this is legal.
REQ-037 mem_ready in IDLE, ADDR or DONE SHALL be ignored.

Reset
REQ-038 rst = 0 SHALL immediately force IDLE, k = 0, and mem_rd, mem_wr, busy, done and wrap to 0, with mem_addr, mem_wdata and rdata_vec set to all zeros.
REQ-039 Reset during XFER SHALL abort the transfer with no further memory request, and rdata_vec SHALL read zero afterward.
REQ-040 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-041 Load with base_addr=0x0100, offset=6'h3E (-2), stride=1, mem_ready=1 -> addresses 0x00FE..0x010D, rdata_vec lanes equal the memory model, done at edge 18, wrap=0.
REQ-042 Store with base=0x0020, offset=5, stride=2, lane k = 0xA000+k, mem_ready low for 3 cycles on lane 4 -> lane 4 signals held stable for 4 cycles, memory at 0x25+2k = 0xA000+k.
REQ-043 Load with base=0xFFF8, offset=0, stride=1 -> lanes 8..15 address 0x0000..0x0007, wrap=1 after done.
REQ-044 start pulsed again at cycle 5 of an active load -> ignored, one done only, operands unchanged.
REQ-045 rst driven low at lane 7 of a store -> mem_wr=0 immediately, no further writes, all outputs zero; a new load after reset completes normally.
REQ-046 Run with LANES=4 and WORD_W=32 -> done at edge 6, 128-bit packing correct.
